// File: rtl/max_frame_serializer_if.sv
// Parallel word handshake feeding max_frame_serializer: a word moves on a rising
// edge where in_valid && in_ready; in_data must hold steady while in_valid waits.
interface max_frame_serializer_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/max_frame_serializer.sv
// Buffers WIDTH-bit words in a DEPTH-entry FIFO and emits each as a start-flagged serial frame.
// Define MFS_LSB_FIRST_EN for LSB-first frames; the default build sends MSB first.
module max_frame_serializer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  max_frame_serializer_if.slave  up,
  output logic                   start,
  output logic                   din,
  output logic                   busy,
  output logic                   dbg_state
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nx;
  logic [WIDTH-1:0] shreg, shreg_nx, shifted, head;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             start_i, start_i_nx, bit_i, bit_i_nx;
  logic             push, pop, load, full, empty, first_bit, next_bit;

  assign full        = (count == (AW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign up.in_ready = !full;
  assign push        = up.in_valid && !full;
  assign head        = mem[rd_ptr];
  assign dbg_state   = state;

`ifdef MFS_LSB_FIRST_EN
  assign shifted   = shreg >> 1;
  assign first_bit = head[0];
  assign next_bit  = shifted[0];
`else
  assign shifted   = shreg << 1;
  assign first_bit = head[WIDTH-1];
  assign next_bit  = shifted[WIDTH-1];
`endif

  // A frame's last bit and the next frame's load share one cycle, so frames are gapless.
  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    cnt_nx     = cnt;
    start_i_nx = 1'b0;
    bit_i_nx   = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: load = !empty;
      SHIFT: begin
        if (cnt != '0) begin
          shreg_nx = shifted;
          bit_i_nx = next_bit;
          cnt_nx   = cnt - CW'(1);
        end else if (!empty) begin
          load = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (load) begin
      shreg_nx   = head;
      cnt_nx     = CW'(WIDTH - 1);
      start_i_nx = 1'b1;
      bit_i_nx   = first_bit;
      state_nx   = SHIFT;
    end
  end

  assign pop = load;

  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + (AW+1)'(1);
      2'b01:   count_nx = count - (AW+1)'(1);
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      start_i <= 1'b0;
      bit_i   <= 1'b0;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      cnt     <= cnt_nx;
      start_i <= start_i_nx;
      bit_i   <= bit_i_nx;
      count   <= count_nx;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      busy    <= (state_nx == SHIFT) || (count_nx != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= up.in_data;
  end

  // Serial outputs move on the falling edge so the detector samples them mid-bit.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start <= 1'b0;
      din   <= 1'b0;
    end else begin
      start <= start_i;
      din   <= bit_i;
    end
  end
endmodule

// File: tb/tb_max_frame_serializer.sv
// Directed bench for max_frame_serializer (WIDTH=16, DEPTH=4), MSB- or LSB-first build.
module tb_max_frame_serializer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic start, din, busy, dbg_state;

  max_frame_serializer_if #(.WIDTH(WIDTH)) up ();

  max_frame_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up        (up.slave),
    .start     (start),
    .din       (din),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_q[$];
  int start_cyc_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [WIDTH-1:0] w);
    chk("push_ready", 32'(up.in_ready), 32'd1);
    up.in_data  = w;
    up.in_valid = 1'b1;
    tick();
    up.in_valid = 1'b0;
    exp_q.push_back(w);
  endtask

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] acc, input logic b);
`ifdef MFS_LSB_FIRST_EN
    return {b, acc[WIDTH-1:1]};
`else
    return {acc[WIDTH-2:0], b};
`endif
  endfunction

  // Frame collector: rebuilds each word from the serial stream as the detector sees it.
  int mon_cnt = 0;
  int cyc = 0;
  logic [WIDTH-1:0] mon_acc = '0;
  always @(posedge clk) begin
    #2;
    cyc++;
    if (!rst_n) begin
      mon_cnt = 0;
    end else begin
      if (start) begin
        start_cyc_q.push_back(cyc);
        mon_cnt = 0;
      end
      if (start || mon_cnt > 0) begin
        mon_acc = shift_in(mon_acc, din);
        mon_cnt++;
        if (mon_cnt == WIDTH) begin
          got_q.push_back(mon_acc);
          mon_cnt = 0;
        end
      end
    end
  end

  initial begin
    logic [15:0] seq, st;
    logic [31:0] seq32, st32;
    logic [15:0] w3 [5];
    int acc_t [5];
    int t, n, run, maxrun;
    logic accepted;
    logic [15:0] one_hot_word;

    up.in_valid = 1'b0;
    up.in_data  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_in_ready", 32'(up.in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // Single word F0F0: start two edges after acceptance, then the 16 bits.
    push_one(16'hF0F0);
    tick();
    chk("s1_start_early", 32'(start), 32'd0);
    seq = '0;
    st  = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      seq = {seq[14:0], din};
      st  = {st[14:0], start};
      if (i == 0) chk("s1_busy", 32'(busy), 32'd1);
    end
    chk("s1_start_pulse", 32'(st), 32'h8000);
`ifdef MFS_LSB_FIRST_EN
    chk("s1_din_seq", 32'(seq), 32'h0F0F);
`else
    chk("s1_din_seq", 32'(seq), 32'hF0F0);
`endif
    chk("s1_busy_drop", 32'(busy), 32'd0);
    run = 0;
    maxrun = 0;
    for (int i = 15; i >= 0; i--) begin
      run = seq[i] ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    chk("s1_max_run", 32'(maxrun), 32'd4);
    tick();
    chk("s1_din_idle", 32'(din), 32'd0);
    chk("s1_start_idle", 32'(start), 32'd0);

    // Back-to-back FFFF, 0007: gapless, second start 16 edges after the first.
    tick();
    start_cyc_q.delete();
    chk("s2_ready", 32'(up.in_ready), 32'd1);
    up.in_valid = 1'b1;
    up.in_data  = 16'hFFFF;
    tick();
    up.in_data  = 16'h0007;
    tick();
    up.in_valid = 1'b0;
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0007);
    seq32 = '0;
    st32  = '0;
    for (int i = 0; i < 32; i++) begin
      tick();
      seq32 = {seq32[30:0], din};
      st32  = {st32[30:0], start};
    end
    chk("s2_start_pos", st32, 32'h8000_8000);
`ifdef MFS_LSB_FIRST_EN
    chk("s2_din_seq", seq32, 32'hFFFF_E000);
`else
    chk("s2_din_seq", seq32, 32'hFFFF_0007);
`endif
    chk("s2_start_count", 32'(start_cyc_q.size()), 32'd2);
    if (start_cyc_q.size() >= 2)
      chk("s2_start_gap", 32'(start_cyc_q[1] - start_cyc_q[0]), 32'd16);
    chk("s2_busy_drop", 32'(busy), 32'd0);

    // Five words with in_valid held: FIFO fills, in_ready returns after first queued pop.
    tick();
    w3[0] = 16'hA5A5; w3[1] = 16'h1234; w3[2] = 16'h8001; w3[3] = 16'h7FFE; w3[4] = 16'hC3C3;
    t = 0;
    up.in_valid = 1'b1;
    for (int idx = 0; idx < 5; idx++) begin
      up.in_data = w3[idx];
      exp_q.push_back(w3[idx]);
      accepted = 1'b0;
      for (int g = 0; g < 40 && !accepted; g++) begin
        accepted = up.in_ready;
        tick();
        t++;
      end
      acc_t[idx] = t;
      if (!accepted) chk("s3_accept_timeout", 32'd0, 32'd1);
    end
    up.in_valid = 1'b0;
    chk("s3_full_ready", 32'(up.in_ready), 32'd0);
    chk("s3_accept_span", 32'(acc_t[4] - acc_t[0]), 32'd4);
    n = 0;
    while (!up.in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("s3_ready_rise", 32'(n), 32'd13);
    repeat (80) tick();
    chk("s3_busy_drop", 32'(busy), 32'd0);

    // Reset during bit 7 of a frame with two words queued.
    up.in_valid = 1'b1;
    up.in_data  = 16'hFFFF;
    tick();
    up.in_data  = 16'h1234;
    tick();
    up.in_data  = 16'h5678;
    tick();
    up.in_valid = 1'b0;
    repeat (7) tick();
    chk("s4_din_before", 32'(din), 32'd1);
    chk("s4_ready_before", 32'(up.in_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("s4_start_clr", 32'(start), 32'd0);
    chk("s4_din_clr", 32'(din), 32'd0);
    chk("s4_in_ready", 32'(up.in_ready), 32'd1);
    chk("s4_busy_clr", 32'(busy), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    start_cyc_q.delete();
    repeat (20) tick();
    chk("s4_no_start", 32'(start_cyc_q.size()), 32'd0);
    chk("s4_busy_idle", 32'(busy), 32'd0);

    // Push lands on the same edge as the last-bit pop with one word queued.
    start_cyc_q.delete();
    up.in_valid = 1'b1;
    up.in_data  = 16'h00FF;
    tick();
    up.in_data  = 16'h3C3C;
    tick();
    up.in_valid = 1'b0;
    exp_q.push_back(16'h00FF);
    exp_q.push_back(16'h3C3C);
    repeat (15) tick();
    chk("s5_ready", 32'(up.in_ready), 32'd1);
    up.in_valid = 1'b1;
    up.in_data  = 16'h8001;
    tick();
    up.in_valid = 1'b0;
    exp_q.push_back(16'h8001);
    chk("s5_busy", 32'(busy), 32'd1);
    repeat (50) tick();
    chk("s5_start_count", 32'(start_cyc_q.size()), 32'd3);
    if (start_cyc_q.size() >= 3) begin
      chk("s5_gap1", 32'(start_cyc_q[1] - start_cyc_q[0]), 32'd16);
      chk("s5_gap2", 32'(start_cyc_q[2] - start_cyc_q[1]), 32'd16);
    end

    // Single set bit that must lead the frame in either bit order.
`ifdef MFS_LSB_FIRST_EN
    one_hot_word = 16'h0001;
`else
    one_hot_word = 16'h8000;
`endif
    tick();
    push_one(one_hot_word);
    tick();
    seq = '0;
    st  = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      seq = {seq[14:0], din};
      st  = {st[14:0], start};
    end
    chk("s6_din_seq", 32'(seq), 32'h8000);
    chk("s6_start_pulse", 32'(st), 32'h8000);

    // Every completed frame must match its pushed word, in push order.
    repeat (4) tick();
    chk("sb_count", 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk("sb_frame", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/max_frame_serializer.md
# max_frame_serializer

Upstream feeder for the run-length maximum detector. It accepts parallel WIDTH-bit words over a valid/ready handshake and buffers them in a small FIFO. Each word goes out as one serial frame: a one-cycle `start` pulse, then WIDTH data bits on `din`. Both outputs change on the falling clock edge, so the detector samples them mid-bit on the rising edge.

## Interface
- `WIDTH`, 16: bits per frame; legal range 1..31, so a full-ones frame fits the detector's 5-bit length.
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `clk` input 1: single clock; internal state on rising edge, `start`/`din` registers on falling edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_data` input WIDTH: word to serialize.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: FIFO can accept; combinational `!full`.
- `start` output 1: frame-start pulse, high for exactly one cycle, coincident with the first data bit.
- `din` output 1: serial data bit.
- `busy` output 1: FIFO non-empty or frame in progress.

## Operation
- Push: at a rising edge with `in_valid && in_ready`, `in_data` is written at the FIFO write pointer. A word is never taken while `in_ready`=0.
- Internal FSM states are IDLE and SHIFT. The FSM holds a shift register of WIDTH bits and a bit counter of ceil(log2(WIDTH)) bits.
- IDLE, FIFO non-empty:
  - pop one word and load the shift register;
  - set counter = WIDTH-1;
  - set internal `start_i`=1 and `bit_i` = first bit;
  - go to SHIFT.
- IDLE, FIFO empty: `start_i`=0, `bit_i`=0.
- SHIFT, counter > 0: shift, present the next bit, `start_i`=0, decrement the counter.
- SHIFT, counter = 0 (last bit presented):
  - FIFO non-empty: pop and reload exactly as from IDLE. Frames are gapless.
  - FIFO empty: go to IDLE with `bit_i`=0.
- Output registers: at each falling edge, `start` <= `start_i` and `din` <= `bit_i`.
- Bit order: MSB first by default (see Configuration).
- Simultaneous push and pop on a non-full FIFO: both take effect and the count is unchanged. When the FIFO is full, only the pop occurs because `in_ready`=0. `in_ready` rises in the cycle after the pop.
- Pointers wrap modulo DEPTH. full/empty are derived from a count register ranging 0..DEPTH.
- Reset values: FIFO count and pointers 0, FSM IDLE, counter 0, `start`=0, `din`=0, `in_ready`=1, `busy`=0.
- Reset mid-frame: outputs clear immediately (asynchronous), the FIFO is flushed, and the partial frame is abandoned. No further `start` appears until a new word is pushed.

## Timing
- Word accepted at rising edge k into an empty FIFO with the FSM idle:
  - pop and load at rising edge k+1;
  - `start`=1 and `din` = bit 0 driven from falling edge k+1;
  - sampled by the detector at rising edge k+2.
- Frame bit i is sampled at rising edge k+2+i. The last bit is sampled at k+1+WIDTH.
- A queued next frame has its `start` sampled at k+2+WIDTH, with zero idle cycles.
- `start` is never high in two consecutive cycles unless WIDTH=1.
- `busy` is registered on the rising edge. It falls one cycle after the last bit is presented when no word is queued.
- Sustained throughput: one word per WIDTH cycles. The producer stalls via `in_ready` once DEPTH words are queued.

## Configuration
- `MFS_LSB_FIRST_EN` defined: each frame is emitted LSB first (bit 0 of the word in the `start` cycle). The shift register shifts right.
- Not defined: MSB first (bit WIDTH-1 in the `start` cycle). The shift register shifts left.
- Handshake, FIFO and timing are identical in both builds.

## Test plan
All scenarios use WIDTH=16 and DEPTH=4.
- Single word 16'hF0F0 pushed, MSB build:
  - `start` sampled high for one rising edge, 2 edges after acceptance.
  - `din` sequence 1111000011110000.
  - `busy` drops afterwards; the downstream detector reports length 4.
- Words 16'hFFFF and 16'h0007 pushed back-to-back:
  - the second `start` is sampled exactly 16 edges after the first;
  - no gap cycle between frames; the `din` tail is ...111 0000000000000111.
- Five words pushed with `in_valid` held high while the FSM is busy: `in_ready` drops after the fourth is queued and rises exactly one cycle after the first pop of a queued word. All five frames are emitted in push order.
- `rst_n` pulsed low during bit 7 of a frame, with 2 words queued:
  - `start`/`din` go 0 immediately and `in_ready`=1;
  - no `start` for 20 cycles after release with `in_valid`=0.
- LSB build, word 16'h0001: `din` is 1 in the `start` cycle, then 15 zeros.
- Push on the same edge as the last-bit pop with FIFO count 1: count stays 1, and the next frame follows gaplessly.
